// File: rtl/router_ctrl.sv
// router_ctrl: control plane of the 1x3 router.
//   Sequences header decode, payload and parity writes into three output FIFOs,
//   selects the target FIFO, stalls the source on full/busy, and runs per-port
//   read timeouts that soft-reset an output FIFO whose packet is not drained.
// Ports:
//   clock, reset (async, active-high)
//   pkt_valid, header_addr[1:0]       : source byte present / header target port
//   fifo_full[2:0], fifo_empty[2:0]   : per-FIFO status flags
//   read_enb[2:0]                     : downstream read enables
//   parity_done, low_pkt_valid        : handshakes from the register block
//   write_enb[2:0]                    : one-hot FIFO write enable
//   vld_out[2:0]                      : per-port data available (~fifo_empty)
//   soft_reset[2:0]                   : one-cycle pulse on read timeout
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   rst_int_reg, write_enb_reg, busy  : state decode strobes
module router_ctrl #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] header_addr,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;

    state_t           state, state_next;
    logic [1:0]       addr_q;
    logic [CNT_W-1:0] cnt [3];

    // Port select with address 3 mapping to 0 so it never indexes out of range.
    function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    pick = v[0];
            2'd1:    pick = v[1];
            2'd2:    pick = v[2];
            default: pick = 1'b0;
        endcase
    endfunction

    logic hdr_ok;
    assign hdr_ok  = pkt_valid && (header_addr != 2'd3);
    assign vld_out = ~fifo_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_q <= header_addr;
        end
    end

    always_comb begin
        state_next    = state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (hdr_ok)
                    state_next = pick(fifo_empty, header_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
                state_next    = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
                if (pick(fifo_full, addr_q))
                    state_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!pick(fifo_full, addr_q))
                    state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done)
                    state_next = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_next = LOAD_PARITY;
                else
                    state_next = LOAD_DATA;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                state_next    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                state_next  = pick(fifo_full, addr_q) ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (pick(fifo_empty, addr_q))
                    state_next = LOAD_FIRST_DATA;
            end
            default: state_next = DECODE_ADDRESS;
        endcase
        // Timeout on the active port abandons the packet from any state.
        if (state != DECODE_ADDRESS && pick(soft_reset, addr_q))
            state_next = DECODE_ADDRESS;
    end

    assign write_enb = write_enb_reg ? (3'b001 << addr_q) : 3'b000;

    // Per-port timeout: clearing at TIMEOUT-1 both emits the pulse and keeps
    // the counter from ever wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soft_reset <= '0;
            for (int unsigned i = 0; i < 3; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (vld_out[i] && !read_enb[i]) begin
                    if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
                        soft_reset[i] <= 1'b1;
                        cnt[i]        <= '0;
                    end else begin
                        soft_reset[i] <= 1'b0;
                        cnt[i]        <= cnt[i] + 1'b1;
                    end
                end else begin
                    soft_reset[i] <= 1'b0;
                    cnt[i]        <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
module tb_router_ctrl;

    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] header_addr = 2'd0;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_enb = 3'b111;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    router_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .header_addr(header_addr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];

    // Reference model: named phase, target port, unread run lengths, pulse flags.
    string      m_state = "DECODE";
    logic [1:0] m_addr = 2'd0;
    int         m_run[3];
    logic [2:0] m_sr = 3'b000;

    task automatic model_reset();
        m_state = "DECODE";
        m_addr  = 2'd0;
        m_sr    = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        string      s;
        string      ns;
        logic [2:0] new_sr;
        bit         abort;
        if (reset) begin
            model_reset();
            return;
        end
        s     = m_state;
        abort = (s != "DECODE") && m_sr[m_addr];
        new_sr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!fifo_empty[i] && !read_enb[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == TIMEOUT) begin
                    new_sr[i] = 1'b1;
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        ns = s;
        if (abort) ns = "DECODE";
        else if (s == "DECODE") begin
            if (pkt_valid && header_addr != 2'd3)
                ns = fifo_empty[header_addr] ? "LFD" : "WAIT";
        end else if (s == "LFD") ns = "LD";
        else if (s == "LD") begin
            if (fifo_full[m_addr]) ns = "FULL";
            else if (!pkt_valid) ns = "LP";
        end else if (s == "FULL") begin
            if (!fifo_full[m_addr]) ns = "LAF";
        end else if (s == "LAF") begin
            if (parity_done) ns = "DECODE";
            else if (low_pkt_valid) ns = "LP";
            else ns = "LD";
        end else if (s == "LP") ns = "CPE";
        else if (s == "CPE") ns = fifo_full[m_addr] ? "FULL" : "DECODE";
        else if (s == "WAIT") begin
            if (fifo_empty[m_addr]) ns = "LFD";
        end
        if (s == "DECODE" && pkt_valid && header_addr != 2'd3) m_addr = header_addr;
        m_state = ns;
        m_sr    = new_sr;
    endtask

    function automatic logic [16:0] exp_vec();
        bit         loading;
        logic [2:0] we;
        bit         da, lf, ld, la, fu, ri, bz;
        loading = (m_state == "LFD") || (m_state == "LD") || (m_state == "LP") || (m_state == "LAF");
        we = loading ? (3'b001 << m_addr) : 3'b000;
        da = (m_state == "DECODE");
        lf = (m_state == "LFD");
        ld = (m_state == "LD");
        la = (m_state == "LAF");
        fu = (m_state == "FULL");
        ri = (m_state == "CPE");
        bz = !(da || ld);
        return {we, ~fifo_empty, m_sr, da, lf, ld, la, fu, ri, loading, bz};
    endfunction

    task automatic drv(input logic rs, input logic pv, input logic [1:0] ha,
                       input logic [2:0] ff, input logic [2:0] fe, input logic [2:0] re,
                       input logic pd, input logic lpv);
        @(posedge clock);
        model_edge();
        #2;
        reset = rs; pkt_valid = pv; header_addr = ha; fifo_full = ff;
        fifo_empty = fe; read_enb = re; parity_done = pd; low_pkt_valid = lpv;
        if (rs) model_reset();
        exp_q.push_back(exp_vec());
    endtask

    // Monitor: every falling edge, compare DUT outputs against the oldest expectation.
    int mon_cycle = 0;
    initial begin
        logic [16:0] got, want;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {write_enb, vld_out, soft_reset, detect_add, lfd_state, ld_state,
                        laf_state, full_state, rst_int_reg, write_enb_reg, busy};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b required %b (we,vld,sr,da,lfd,ld,laf,full,rir,wer,busy)",
                             mon_cycle, got, want);
                end
                mon_cycle++;
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Full packet to port 1.
        for (int i = 0; i < 15; i++) drv(1'b0, 1'b1, 2'd1, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Invalid header address 3.
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 2'd3, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Wait for port 2 to empty.
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 2'd2, 3'b000, 3'b011, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 2'd2, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Full stall on port 1, resume with low_pkt_valid.
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 2'd1, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 2'd1, 3'b010, 3'b111, 3'b111, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 2'd1, 3'b000, 3'b111, 3'b111, 1'b0, 1'b1);
        drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Reset mid-packet.
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Timeout on idle port 0, then a read on the 29th cycle suppresses it.
        for (int i = 0; i < 32; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b110, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 28; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b110, 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Timeout on the active port aborts the packet.
        drv(1'b0, 1'b1, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 35; i++) drv(1'b0, 1'b1, 2'd0, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] ff, fe, re;
            for (int b = 0; b < 3; b++) begin
                ff[b] = ($urandom_range(7) == 0);
                fe[b] = ($urandom_range(3) != 0);
                re[b] = ($urandom_range(3) != 0);
            end
            drv(($urandom_range(199) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
                ff, fe, re, ($urandom_range(7) == 0), ($urandom_range(3) == 0));
        end
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
